// File: rtl/registro_bank.sv
// rtl/registro_bank.sv - double-buffered register bank with byte-lane writes and atomic commit
module registro_bank #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 3,
    localparam int NBYTES    = WIDTH / 8,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cl,
    input  logic                  w,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [NBYTES-1:0]     be,
    input  logic [WIDTH-1:0]      din,
    input  logic                  commit,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  rsel,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH-1:0]      dirty,
    output logic                  commit_done
);

    logic [WIDTH-1:0] staging [DEPTH];
    logic [WIDTH-1:0] active  [DEPTH];
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic [DEPTH-1:0] dirty_next;

    assign wr_en = w && (|be);

    // Byte-merge of the addressed staging word; lanes without an enable keep their value.
    always_comb begin
        wr_data = staging[waddr];
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                wr_data[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // A commit retires every previously dirty entry; a same-cycle write re-marks its own entry.
    always_comb begin
        dirty_next = commit ? '0 : dirty;
        if (wr_en) begin
            dirty_next[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                staging[n] <= '0;
                active[n]  <= '0;
            end
            dirty       <= '0;
            dout        <= '0;
            commit_done <= 1'b0;
        end else if (cl) begin
            for (int n = 0; n < DEPTH; n++) begin
                staging[n] <= '0;
                active[n]  <= '0;
            end
            dirty       <= '0;
            dout        <= '0;
            commit_done <= 1'b0;
        end else begin
            // Active copy takes the pre-write staging value, so a colliding write waits for the next commit.
            for (int n = 0; n < DEPTH; n++) begin
                if (commit && dirty[n]) begin
                    active[n] <= staging[n];
                end
            end
            if (wr_en) begin
                staging[waddr] <= wr_data;
            end
            dirty       <= dirty_next;
            commit_done <= commit;
            dout        <= rsel ? staging[raddr] : active[raddr];
        end
    end

endmodule

// File: tb/tb_registro_bank.sv
// tb/tb_registro_bank.sv - randomized and directed check of registro_bank against an array model
module tb_registro_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cl = 1'b0;
    logic        w = 1'b0;
    logic [2:0]  waddr = '0;
    logic [3:0]  be = '0;
    logic [31:0] din = '0;
    logic        commit = 1'b0;
    logic [2:0]  raddr = '0;
    logic        rsel = 1'b0;
    logic [31:0] dout;
    logic [7:0]  dirty;
    logic        commit_done;

    int total = 0;
    int bad = 0;

    logic [31:0] stg [8];
    logic [31:0] act [8];
    logic [7:0]  drt;
    logic [31:0] exp_dout;
    logic        exp_done;

    registro_bank dut (
        .clk(clk), .rst(rst), .cl(cl), .w(w), .waddr(waddr), .be(be), .din(din),
        .commit(commit), .raddr(raddr), .rsel(rsel), .dout(dout), .dirty(dirty),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 8; n++) begin
            stg[n] = '0;
            act[n] = '0;
        end
        drt = '0;
    endtask

    // One clock: apply inputs, advance the model by the rules of the bank, compare after the edge.
    task automatic cycle(input logic i_w, input logic [2:0] i_wa, input logic [3:0] i_be,
                         input logic [31:0] i_din, input logic i_commit,
                         input logic [2:0] i_ra, input logic i_rsel, input logic i_cl);
        w = i_w; waddr = i_wa; be = i_be; din = i_din; commit = i_commit;
        raddr = i_ra; rsel = i_rsel; cl = i_cl;
        @(posedge clk);
        if (i_cl) begin
            model_clear();
            exp_dout = '0;
            exp_done = 1'b0;
        end else begin
            exp_dout = i_rsel ? stg[i_ra] : act[i_ra];
            exp_done = i_commit;
            if (i_commit) begin
                for (int n = 0; n < 8; n++)
                    if (drt[n]) act[n] = stg[n];
                drt = '0;
            end
            if (i_w && i_be != 4'b0) begin
                for (int i = 0; i < 4; i++)
                    if (i_be[i]) stg[i_wa][8*i +: 8] = i_din[8*i +: 8];
                drt[i_wa] = 1'b1;
            end
        end
        #1;
        chk("dout", dout, exp_dout);
        chk("dirty", {24'b0, dirty}, {24'b0, drt});
        chk("commit_done", {31'b0, commit_done}, {31'b0, exp_done});
        w = 1'b0; commit = 1'b0; cl = 1'b0; be = '0;
    endtask

    task automatic idle_read(input logic [2:0] a, input logic s);
        cycle(1'b0, 3'd0, 4'h0, 32'h0, 1'b0, a, s, 1'b0);
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_dirty", {24'b0, dirty}, 32'h0);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) begin
            idle_read(3'(a), 1'b0);
            idle_read(3'(a), 1'b1);
        end

        cycle(1'b1, 3'd4, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd4, 1'b1, 1'b1);
        idle_read(3'd4, 1'b1);
        chk("clear_stg4", dout, 32'h0);

        // Byte-lane merge and empty-strobe write
        cycle(1'b1, 3'd2, 4'hF, 32'hAABBCCDD, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 4'h5, 32'h11223344, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 4'h0, 32'hFFFFFFFF, 1'b0, 3'd2, 1'b1, 1'b0);
        chk("lane_merge", dout, 32'hAA22CC44);
        chk("lane_dirty", {24'b0, dirty}, 32'h04);
        idle_read(3'd2, 1'b0);
        chk("lane_active", dout, 32'h0);
        cycle(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd0, 1'b0, 1'b0);

        // Atomic commit of entries 0, 5, 7
        cycle(1'b1, 3'd0, 4'hF, 32'h00000010, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 4'hF, 32'h00000050, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 4'hF, 32'h00000070, 1'b0, 3'd5, 1'b0, 1'b0);
        chk("pre_commit_dirty", {24'b0, dirty}, 32'hA1);
        cycle(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd7, 1'b0, 1'b0);
        chk("pre_commit_read", dout, 32'h0);
        chk("commit_pulse", {31'b0, commit_done}, 32'h1);
        idle_read(3'd7, 1'b0);
        chk("post_commit_read", dout, 32'h70);
        chk("pulse_once", {31'b0, commit_done}, 32'h0);

        // Write+commit collision on entry 1
        cycle(1'b1, 3'd1, 4'hF, 32'h3, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 4'hF, 32'h5, 1'b1, 3'd0, 1'b0, 1'b0);
        chk("collide_dirty", {24'b0, dirty}, 32'h02);
        idle_read(3'd1, 1'b0);
        idle_read(3'd1, 1'b1);
        chk("collide_stg", dout, 32'h5);
        cycle(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("collide_act_old", dout, 32'h3);
        idle_read(3'd1, 1'b0);
        chk("collide_act_new", dout, 32'h5);

        // Clear beats write and commit
        cycle(1'b1, 3'd6, 4'hF, 32'h66, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 4'hF, 32'h77, 1'b1, 3'd0, 1'b0, 1'b1);
        idle_read(3'd6, 1'b1);
        chk("clear_done", {31'b0, commit_done}, 32'h0);

        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), $urandom,
                  ($urandom_range(0, 4) == 0), 3'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 40) == 0));
        end

        // Async reset in the middle of a commit cycle
        cycle(1'b1, 3'd3, 4'hF, 32'h12345678, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3, 1'b1, 1'b0);
        w = 1'b1; waddr = 3'd4; be = 4'hF; din = 32'hCAFEF00D; commit = 1'b1;
        #4;
        rst = 1'b1;
        #1;
        chk("async_dout", dout, 32'h0);
        chk("async_dirty", {24'b0, dirty}, 32'h0);
        chk("async_done", {31'b0, commit_done}, 32'h0);
        w = 1'b0; commit = 1'b0; be = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int a = 0; a < 8; a++) begin
            idle_read(3'(a), 1'b0);
            idle_read(3'(a), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
